// File: rtl/lc3b_types.sv
// Shared control-flow types: op codes, reservation entry and resolution bundle.
// Datapath widths here must match the WORD_W / ROB_ID_W parameters of cf_resolution_unit.
package lc3b_types;

   localparam int unsigned CF_WORD_W   = 16;
   localparam int unsigned CF_ROB_ID_W = 4;
   localparam int unsigned CF_AGE_W    = 4;

   localparam logic [3:0] CF_BRANCH = 4'h0;
   localparam logic [3:0] CF_JSR    = 4'h4;
   localparam logic [3:0] CF_JSRR   = 4'h5;
   localparam logic [3:0] CF_JUMP   = 4'hC;

   typedef struct packed {
      logic                   busy;
      logic [3:0]             op;
      logic [CF_WORD_W-1:0]   pc;
      logic [CF_WORD_W-1:0]   vj;
      logic [CF_WORD_W-1:0]   vk;
      logic                   qj_pend;
      logic [CF_ROB_ID_W-1:0] qj;
      logic                   qk_pend;
      logic [CF_ROB_ID_W-1:0] qk;
      logic [CF_ROB_ID_W-1:0] dest;
      logic [CF_AGE_W-1:0]    age;
      logic                   pred_taken;
      logic [CF_WORD_W-1:0]   pred_pc;
   } cf_res_entry;

   typedef struct packed {
      logic [CF_ROB_ID_W-1:0] dest;
      logic [CF_WORD_W-1:0]   value;
      logic [CF_WORD_W-1:0]   pc;
      logic [3:0]             op;
      logic                   taken;
      logic [CF_WORD_W-1:0]   target;
      logic [CF_WORD_W-1:0]   new_pc;
      logic                   redirect;
   } cf_resolution;

   function automatic logic cf_is_known(input logic [3:0] op);
      return (op == CF_BRANCH) || (op == CF_JSR) || (op == CF_JSRR) || (op == CF_JUMP);
   endfunction

endpackage

// File: rtl/cf_resolve.sv
// Combinational resolution of one control-flow op: direction, target, next PC and link value.
module cf_resolve
   import lc3b_types::*;
#(
   parameter int unsigned WORD_W = 16
) (
   input  logic [3:0]        op,
   input  logic [WORD_W-1:0] pc,
   input  logic [WORD_W-1:0] vj,
   input  logic [WORD_W-1:0] vk,
   output logic              taken,
   output logic [WORD_W-1:0] target,
   output logic [WORD_W-1:0] new_pc,
   output logic [WORD_W-1:0] value
);

   logic [WORD_W-1:0] pc_next;
   logic [WORD_W-1:0] br_off;
   logic [WORD_W-1:0] br_target;
   logic              br_taken;
   logic              unused_vk;

   assign pc_next   = pc + WORD_W'(2);
   assign br_off    = {{(WORD_W-10){vk[8]}}, vk[8:0], 1'b0};
   assign br_target = pc_next + br_off;
   // vk[11:9] are the n/z/p condition bits tested against vj
   assign br_taken  = (vk[11] && vj[WORD_W-1]) || (vk[10] && (vj == '0)) ||
                      (vk[9] && !vj[WORD_W-1] && (vj != '0));
   assign unused_vk = ^vk[WORD_W-1:12];

   always_comb begin
      taken  = 1'b0;
      target = '0;
      new_pc = pc_next;
      value  = '0;
      case (op)
         CF_JUMP: begin
            taken  = 1'b1;
            target = vj;
            new_pc = vj;
         end
         CF_JSR: begin
            taken  = 1'b1;
            value  = pc_next;
            target = pc_next + vj;
            new_pc = pc_next + vj;
         end
         CF_JSRR: begin
            taken  = 1'b1;
            value  = pc_next;
            target = vj;
            new_pc = vj;
         end
         CF_BRANCH: begin
            taken  = br_taken;
            target = br_target;
            new_pc = br_taken ? br_target : pc_next;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cf_resolution_unit.sv
// Control-flow reservation stations: CDB wakeup, oldest-ready select, registered resolution.
// Define CF_BRANCH_PREDICTION_EN to store predictions and redirect only on mispredict.
module cf_resolution_unit
   import lc3b_types::*;
#(
   parameter int unsigned NUM_STATIONS = 4,
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned ROB_ID_W     = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                disp_valid,
   output logic                disp_ready,
   input  logic [3:0]          disp_op,
   input  logic [WORD_W-1:0]   disp_pc,
   input  logic [WORD_W-1:0]   disp_vj,
   input  logic [WORD_W-1:0]   disp_vk,
   input  logic                disp_qj_pend,
   input  logic                disp_qk_pend,
   input  logic [ROB_ID_W-1:0] disp_qj,
   input  logic [ROB_ID_W-1:0] disp_qk,
   input  logic [ROB_ID_W-1:0] disp_dest,
   input  logic                disp_pred_taken,
   input  logic [WORD_W-1:0]   disp_pred_pc,
   input  logic                cdb_valid,
   input  logic [ROB_ID_W-1:0] cdb_tag,
   input  logic [WORD_W-1:0]   cdb_value,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ROB_ID_W-1:0] res_dest,
   output logic [WORD_W-1:0]   res_value,
   output logic [WORD_W-1:0]   res_pc,
   output logic [3:0]          res_op,
   output logic                res_taken,
   output logic [WORD_W-1:0]   res_target,
   output logic [WORD_W-1:0]   res_new_pc,
   output logic                res_redirect
);

   localparam int unsigned IDX_W = $clog2(NUM_STATIONS);

   cf_res_entry         entries_q [NUM_STATIONS];
   cf_res_entry         entries_d [NUM_STATIONS];
   cf_res_entry         new_entry;
   cf_res_entry         sel_entry;
   cf_resolution        res_q;
   cf_resolution        res_d;
   logic                res_valid_q;
   logic                any_free;
   logic                any_sel;
   logic [IDX_W-1:0]    free_idx;
   logic [IDX_W-1:0]    sel_idx;
   logic [CF_AGE_W-1:0] sel_age;
   logic                alloc;
   logic                issue;
   logic                r_taken;
   logic                r_redirect;
   logic [WORD_W-1:0]   r_target;
   logic [WORD_W-1:0]   r_new_pc;
   logic [WORD_W-1:0]   r_value;
   logic                unused_bits;

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = NUM_STATIONS - 1; i >= 0; i--) begin
         if (!entries_q[i].busy) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // Ages are unique among busy entries, so the strict compare yields a single winner
   always_comb begin
      any_sel = 1'b0;
      sel_idx = '0;
      sel_age = '0;
      for (int i = 0; i < NUM_STATIONS; i++) begin
         if (entries_q[i].busy && !entries_q[i].qj_pend && !entries_q[i].qk_pend &&
             (!any_sel || (entries_q[i].age > sel_age))) begin
            any_sel = 1'b1;
            sel_idx = IDX_W'(i);
            sel_age = entries_q[i].age;
         end
      end
   end

   assign sel_entry  = entries_q[sel_idx];
   assign disp_ready = any_free && !flush;
   assign alloc      = disp_valid && disp_ready;
   assign issue      = any_sel && (!res_valid_q || res_ready) && !flush;

   always_comb begin
      new_entry         = '0;
      new_entry.busy    = 1'b1;
      new_entry.op      = disp_op;
      new_entry.pc      = disp_pc;
      new_entry.dest    = disp_dest;
      new_entry.qj      = disp_qj;
      new_entry.qk      = disp_qk;
      new_entry.vj      = disp_vj;
      new_entry.vk      = disp_vk;
      new_entry.qj_pend = disp_qj_pend;
      new_entry.qk_pend = disp_qk_pend;
      if (disp_qj_pend && cdb_valid && (cdb_tag == disp_qj)) begin
         new_entry.vj      = cdb_value;
         new_entry.qj_pend = 1'b0;
      end
      if (disp_qk_pend && cdb_valid && (cdb_tag == disp_qk)) begin
         new_entry.vk      = cdb_value;
         new_entry.qk_pend = 1'b0;
      end
`ifdef CF_BRANCH_PREDICTION_EN
      new_entry.pred_taken = disp_pred_taken;
      new_entry.pred_pc    = disp_pred_pc;
`endif
   end

   // Issue compacts ages above the freed entry so they stay within 0..busy-1
   always_comb begin
      for (int i = 0; i < NUM_STATIONS; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].busy) begin
            if (cdb_valid && entries_q[i].qj_pend && (entries_q[i].qj == cdb_tag)) begin
               entries_d[i].vj      = cdb_value;
               entries_d[i].qj_pend = 1'b0;
            end
            if (cdb_valid && entries_q[i].qk_pend && (entries_q[i].qk == cdb_tag)) begin
               entries_d[i].vk      = cdb_value;
               entries_d[i].qk_pend = 1'b0;
            end
            if (alloc) begin
               entries_d[i].age = entries_d[i].age + CF_AGE_W'(1);
            end
            if (issue && (entries_q[i].age > sel_age)) begin
               entries_d[i].age = entries_d[i].age - CF_AGE_W'(1);
            end
            if (issue && (sel_idx == IDX_W'(i))) begin
               entries_d[i].busy = 1'b0;
            end
         end
         if (alloc && (free_idx == IDX_W'(i))) begin
            entries_d[i] = new_entry;
         end
      end
   end

   cf_resolve #(
      .WORD_W(WORD_W)
   ) u_resolve (
      .op    (sel_entry.op),
      .pc    (sel_entry.pc),
      .vj    (sel_entry.vj),
      .vk    (sel_entry.vk),
      .taken (r_taken),
      .target(r_target),
      .new_pc(r_new_pc),
      .value (r_value)
   );

`ifdef CF_BRANCH_PREDICTION_EN
   assign r_redirect  = cf_is_known(sel_entry.op) &&
                        ((r_taken != sel_entry.pred_taken) || (r_new_pc != sel_entry.pred_pc));
   assign unused_bits = ^sel_entry;
`else
   assign r_redirect  = r_taken;
   assign unused_bits = ^{sel_entry, disp_pred_taken, disp_pred_pc};
`endif

   always_comb begin
      res_d          = '0;
      res_d.dest     = sel_entry.dest;
      res_d.value    = r_value;
      res_d.pc       = sel_entry.pc;
      res_d.op       = sel_entry.op;
      res_d.taken    = r_taken;
      res_d.target   = r_target;
      res_d.new_pc   = r_new_pc;
      res_d.redirect = r_redirect;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_STATIONS; i++) entries_q[i] <= '0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_STATIONS; i++) entries_q[i] <= '0;
         res_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_STATIONS; i++) entries_q[i] <= entries_d[i];
         if (issue) begin
            res_valid_q <= 1'b1;
            res_q       <= res_d;
         end else if (res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   assign res_valid    = res_valid_q;
   assign res_dest     = res_q.dest;
   assign res_value    = res_q.value;
   assign res_pc       = res_q.pc;
   assign res_op       = res_q.op;
   assign res_taken    = res_q.taken;
   assign res_target   = res_q.target;
   assign res_new_pc   = res_q.new_pc;
   assign res_redirect = res_q.redirect;

endmodule
